// File: rtl/bnn_infer_sched_if.sv
// Requester/consumer handshake bundle for the shared BNN inference scheduler.
interface bnn_infer_sched_if #(
    parameter int unsigned REQ_CNT   = 4,
    parameter int unsigned FEAT_CNT  = 19,
    parameter int unsigned FEAT_BITS = 4,
    parameter int unsigned CLASS_CNT = 3
);
    localparam int unsigned IW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int unsigned PW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int unsigned FW = FEAT_CNT * FEAT_BITS;

    logic [REQ_CNT-1:0]    req_valid;
    logic [REQ_CNT-1:0]    req_ready;
    logic [REQ_CNT*FW-1:0] req_features;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [PW-1:0]         rsp_prediction;

    // Front-end / result-consumer side
    modport master (
        output req_valid, req_features, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prediction
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_features, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prediction
    );
endinterface

// File: rtl/bnn_infer_sched.sv
// Round-robin scheduler sharing one sequential BNN core among several requesters.
module bnn_infer_sched #(
    parameter  int unsigned REQ_CNT   = 4,
    parameter  int unsigned FEAT_CNT  = 19,
    parameter  int unsigned FEAT_BITS = 4,
    parameter  int unsigned CLASS_CNT = 3,
    parameter  int unsigned LATENCY   = 45,
    localparam int unsigned IW        = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1,
    localparam int unsigned PW        = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
    localparam int unsigned FW        = FEAT_CNT * FEAT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    bnn_infer_sched_if.slave    bus,
    output logic                core_rst,
    output logic [FW-1:0]       core_features,
    input  logic [PW-1:0]       core_prediction,
    output logic                busy
);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic [IW-1:0] r_rsp_id;
    logic [PW-1:0] r_rsp_pred;
    logic [FW-1:0] r_core_feat;
    logic          r_core_rst;
    logic          r_busy;

    logic          w_grant_vld;
    logic [IW-1:0] w_grant_idx;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_next_ptr;
    logic [FW-1:0] w_feat;

    // Cyclic first-valid search starting at the round-robin pointer
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            w_idx = IW'((32'(r_rr_ptr) + k) % REQ_CNT);
            if (!w_grant_vld && bus.req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    // Feature slice of the granted requester and the pointer that follows it
    always_comb begin
        w_feat = '0;
        for (int unsigned k = 0; k < REQ_CNT; k++) begin
            if (w_grant_idx == IW'(k)) begin
                w_feat = bus.req_features[k*FW +: FW];
            end
        end
        w_next_ptr = (w_grant_idx == IW'(REQ_CNT - 1)) ? '0 : w_grant_idx + IW'(1);
    end

    // One-hot accept, only while idle and out of reset
    always_comb begin
        bus.req_ready = '0;
        if (rst && (r_state == S_IDLE) && w_grant_vld) begin
            bus.req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Scheduler FSM with registered core and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_pred  <= '0;
            r_core_feat <= '0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_core_feat <= w_feat;
                        r_rsp_id    <= w_grant_idx;
                        r_rr_ptr    <= w_next_ptr;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt      <= CW'(LATENCY - 1);
                    r_core_rst <= 1'b0;
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_rsp_pred  <= core_prediction;
                        r_rsp_valid <= 1'b1;
                        r_core_rst  <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_id         = r_rsp_id;
    assign bus.rsp_prediction = r_rsp_pred;
    assign core_rst           = r_core_rst;
    assign core_features      = r_core_feat;
    assign busy               = r_busy;
endmodule

// File: tb/tb_bnn_infer_sched.sv
// Directed bench for bnn_infer_sched: a LATENCY=45 instance and a LATENCY=1 instance.
module tb_bnn_infer_sched;
    localparam int unsigned REQ_CNT   = 4;
    localparam int unsigned FEAT_CNT  = 19;
    localparam int unsigned FEAT_BITS = 4;
    localparam int unsigned CLASS_CNT = 3;
    localparam int unsigned FW        = FEAT_CNT * FEAT_BITS;
    localparam int          L0        = 45;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    // Free-running cycle index; the core model outputs it mod 4 so every
    // cycle presents a different class, including the out-of-range 3.
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] core_pred;
    assign core_pred = 2'(cyc % 4);

    bnn_infer_sched_if #(.REQ_CNT(REQ_CNT), .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT)) bus0 ();
    bnn_infer_sched_if #(.REQ_CNT(REQ_CNT), .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT)) bus1 ();

    logic          core_rst0, core_rst1, busy0, busy1;
    logic [FW-1:0] core_feat0, core_feat1;

    bnn_infer_sched #(.REQ_CNT(REQ_CNT), .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
                      .CLASS_CNT(CLASS_CNT), .LATENCY(45)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .core_rst(core_rst0),
        .core_features(core_feat0), .core_prediction(core_pred), .busy(busy0)
    );

    bnn_infer_sched #(.REQ_CNT(REQ_CNT), .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
                      .CLASS_CNT(CLASS_CNT), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .core_rst(core_rst1),
        .core_features(core_feat1), .core_prediction(core_pred), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] fpat(input int i, input int salt);
        return {4{19'(i * 7919 + salt * 131 + 5)}};
    endfunction

    task automatic set_feats(input int salt);
        for (int i = 0; i < 4; i++) bus0.req_features[i*FW +: FW] = fpat(i, salt);
    endtask

    // Wait for an accept on bus0, follow it through LOAD/RUN, stop in the first HOLD cycle.
    task automatic serve(input int exp_id, input int salt, output int acc);
        int n;
        int lows;
        logic [3:0] exp_rdy;
        n    = 0;
        lows = 0;
        #1;
        while (((bus0.req_valid & bus0.req_ready) == 4'b0) && n < 200) begin
            step();
            n++;
        end
        exp_rdy = 4'(1 << exp_id);
        chk("grant", 128'(bus0.req_ready), 128'(exp_rdy));
        acc = cyc;
        step();
        chk("load_core_rst", 128'(core_rst0), 128'(1'b1));
        chk("load_features", 128'(core_feat0), 128'(fpat(exp_id, salt)));
        chk("load_busy", 128'(busy0), 128'(1'b1));
        chk("load_ready_off", 128'(bus0.req_ready), 128'(4'b0));
        n = 0;
        while (!bus0.rsp_valid && n < 200) begin
            step();
            n++;
            if (!core_rst0) lows++;
        end
        chk("rsp_valid", 128'(bus0.rsp_valid), 128'(1'b1));
        chk("rsp_cycle", 128'(cyc - acc), 128'(L0 + 2));
        chk("core_rst_low", 128'(lows), 128'(L0));
        chk("rsp_id", 128'(bus0.rsp_id), 128'(exp_id));
        chk("rsp_pred", 128'(bus0.rsp_prediction), 128'((acc + L0 + 1) % 4));
    endtask

    initial begin
        int acc;
        int acc1;
        int a [5];

        rst = 1'b0;
        bus0.req_valid    = '0;
        bus0.rsp_ready    = 1'b0;
        bus0.req_features = '0;
        bus1.req_valid    = '0;
        bus1.rsp_ready    = 1'b0;
        bus1.req_features = '0;
        repeat (3) step();

        // Reset values
        chk("rst_rsp_valid", 128'(bus0.rsp_valid), 128'(1'b0));
        chk("rst_rsp_id", 128'(bus0.rsp_id), 128'(0));
        chk("rst_rsp_pred", 128'(bus0.rsp_prediction), 128'(0));
        chk("rst_core_feat", 128'(core_feat0), 128'(0));
        chk("rst_core_rst", 128'(core_rst0), 128'(1'b1));
        chk("rst_busy", 128'(busy0), 128'(1'b0));
        rst = 1'b1;
        step();

        // Single request from requester 2, then backpressure with requests pending
        set_feats(1);
        bus0.req_valid = 4'b0100;
        serve(2, 1, acc);
        bus0.req_valid = 4'b1101;
        repeat (10) begin
            step();
            chk("bp_rsp_valid", 128'(bus0.rsp_valid), 128'(1'b1));
            chk("bp_rsp_id", 128'(bus0.rsp_id), 128'(2));
            chk("bp_rsp_pred", 128'(bus0.rsp_prediction), 128'((acc + L0 + 1) % 4));
            chk("bp_req_ready", 128'(bus0.req_ready), 128'(4'b0));
            chk("bp_core_rst", 128'(core_rst0), 128'(1'b1));
        end
        bus0.rsp_ready = 1'b1;
        #1;
        chk("hs_cycle_no_grant", 128'(bus0.req_ready), 128'(4'b0));
        step();

        // Pointer sits at 3; requester 3 withdraws, so 0 wins
        bus0.req_valid = 4'b0101;
        #1;
        chk("withdraw_grant", 128'(bus0.req_ready), 128'(4'b0001));
        serve(0, 1, acc);

        // Pointer now 1: with 0 and 1 valid, 1 must win
        bus0.req_valid = 4'b0011;
        set_feats(2);
        step();
        chk("ptr_after_withdraw", 128'(bus0.req_ready), 128'(4'b0010));
        step();
        bus0.req_valid = 4'b0000;
        chk("mid_load_feat", 128'(core_feat0), 128'(fpat(1, 2)));
        repeat (20) step();
        chk("mid_run_core_rst", 128'(core_rst0), 128'(1'b0));

        // Asynchronous reset in RUN cycle 20
        rst = 1'b0;
        #1;
        chk("arst_rsp_valid", 128'(bus0.rsp_valid), 128'(1'b0));
        chk("arst_rsp_id", 128'(bus0.rsp_id), 128'(0));
        chk("arst_rsp_pred", 128'(bus0.rsp_prediction), 128'(0));
        chk("arst_core_feat", 128'(core_feat0), 128'(0));
        chk("arst_core_rst", 128'(core_rst0), 128'(1'b1));
        chk("arst_busy", 128'(busy0), 128'(1'b0));
        bus0.req_valid = 4'b1010;
        repeat (5) begin
            step();
            chk("inrst_rsp_valid", 128'(bus0.rsp_valid), 128'(1'b0));
            chk("inrst_req_ready", 128'(bus0.req_ready), 128'(4'b0));
        end
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 128'(bus0.req_ready), 128'(4'b0010));
        serve(1, 2, acc);

        // All four valid continuously from pointer 0, rsp_ready tied high
        rst = 1'b0;
        bus0.req_valid = 4'b1111;
        set_feats(3);
        step();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serve(k % 4, 3, a[k]);
            if (k > 0) chk("rr_spacing", 128'(a[k] - a[k-1]), 128'(L0 + 3));
        end
        bus0.req_valid = 4'b0000;
        step();
        chk("rr_idle_after", 128'(busy0), 128'(1'b0));

        // LATENCY=1 instance: single request from requester 0
        bus1.rsp_ready = 1'b1;
        bus1.req_features[0 +: FW] = fpat(5, 7);
        bus1.req_valid = 4'b0001;
        #1;
        chk("l1_grant", 128'(bus1.req_ready), 128'(4'b0001));
        acc1 = cyc;
        step();
        bus1.req_valid = 4'b0000;
        chk("l1_load_core_rst", 128'(core_rst1), 128'(1'b1));
        chk("l1_load_feat", 128'(core_feat1), 128'(fpat(5, 7)));
        step();
        chk("l1_run_core_rst", 128'(core_rst1), 128'(1'b0));
        chk("l1_run_no_rsp", 128'(bus1.rsp_valid), 128'(1'b0));
        step();
        chk("l1_rsp_valid", 128'(bus1.rsp_valid), 128'(1'b1));
        chk("l1_rsp_cycle", 128'(cyc - acc1), 128'(3));
        chk("l1_rsp_pred", 128'(bus1.rsp_prediction), 128'((acc1 + 2) % 4));
        chk("l1_rsp_id", 128'(bus1.rsp_id), 128'(0));
        chk("l1_hold_core_rst", 128'(core_rst1), 128'(1'b1));
        step();
        chk("l1_rsp_cleared", 128'(bus1.rsp_valid), 128'(1'b0));
        chk("l1_idle_busy", 128'(busy1), 128'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
